// File: rtl/jk_drv_pkg.sv
// Shared definitions for the JK excitation driver: FSM state type,
// default FIFO geometry and the J/K excitation function.
// Build option: define JK_TOGGLE_EN to drive every change of q as a toggle
// (j=k=1) instead of a dedicated set/reset.
package jk_drv_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int PTR_W     = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } drv_state_e;

    // Returns {j,k} that moves a JK flop from q to tgt in one edge.
    function automatic logic [1:0] exc(input logic q, input logic tgt);
        logic [1:0] jk;
        jk = 2'b00;
`ifdef JK_TOGGLE_EN
        if (q != tgt) begin
            jk = 2'b11;
        end
`else
        if (!q && tgt) begin
            jk = 2'b10;
        end else if (q && !tgt) begin
            jk = 2'b01;
        end
`endif
        return jk;
    endfunction

endpackage

// File: rtl/jk_drv_fifo.sv
// One-bit-wide target FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module jk_drv_fifo
    import jk_drv_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; a push while full is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK flop so that its q follows a stream of
// target bits, then checks q one cycle after each drive.
// Build option: JK_TOGGLE_EN selects toggle excitation for changes
// (see jk_drv_pkg::exc); checking is the same in both builds.
//
// Input handshake: a target bit is taken at a rising clk edge where
// in_valid && in_ready; in_ready is simply !full, so in_valid while full
// is ignored and the offered bit is not stored.
module jk_excitation_driver
    import jk_drv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    drv_state_e state;
    logic       tgt;
    logic       full;
    logic       empty;
    logic       head;
    logic       pop;

    // A new bit may start only when nothing is being driven or checked.
    assign pop      = !empty && ((state == IDLE) || (state == CHECK));
    assign in_ready = !full;
    assign busy     = (state != IDLE) || !empty;

    jk_drv_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (in_valid),
        .din   (in_bit),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Sequencer: pop -> drive j/k one cycle -> check q the next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tgt      <= 1'b0;
            j        <= 1'b0;
            k        <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tgt      <= head;
                        {j, k}   <= exc(q_fb, head);
                        state    <= DRIVE;
                    end else begin
                        {j, k}   <= 2'b00;
                    end
                end
                DRIVE: begin
                    // The flop captures j/k at this edge; release to hold.
                    {j, k} <= 2'b00;
                    state  <= CHECK;
                end
                CHECK: begin
                    if (q_fb != tgt) begin
                        mismatch <= 1'b1;
                        if (err_cnt != {CNT_W{1'b1}}) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                    end
                    // q_fb is now settled, so it also seeds the next bit.
                    if (!empty) begin
                        tgt    <= head;
                        {j, k} <= exc(q_fb, head);
                        state  <= DRIVE;
                    end else begin
                        {j, k} <= 2'b00;
                        state  <= IDLE;
                    end
                end
                default: begin
                    {j, k} <= 2'b00;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
